md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle RV32M multiply/divide unit that sits beside the combinational ALU in the execute stage.
- Takes the same in1/in2 operand pair plus an M-extension opcode (funct3) and returns a 32-bit result after a fixed iterative latency.
- Uses a start/busy/done handshake so the pipeline stalls while it is busy.

Parameters:
- XLEN, 32, operand/result width
- ITER, XLEN, number of iteration cycles (one result bit per cycle)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- in1  input  XLEN  rs1 operand (multiplicand/dividend)
- in2  input  XLEN  rs2 operand (multiplier/divisor)
- md_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; md_out valid in that cycle
- md_out  output  XLEN  result, held until the next accepted start

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, md_out=0.
  - Counters and internal registers are cleared.
  - Reset mid-operation aborts the operation with no done pulse.
- Accept: start=1 in IDLE latches in1, in2 and md_op. start while busy or in the done cycle is ignored.
- FSM:
  - IDLE -> PREP on start.
  - PREP (1 cycle): compute operand magnitudes and the result sign from md_op signedness. MULHSU treats in1 as signed and in2 as unsigned.
  - PREP -> CALC. CALC runs ITER cycles with a 0..ITER-1 counter.
    - Multiply: radix-2 shift-add into a 2*XLEN product register.
    - Divide: restoring shift-subtract, producing quotient and remainder.
  - CALC -> FIX when the counter reaches ITER-1.
  - FIX (1 cycle): apply sign correction and select the result word; register md_out; done=1. Then -> IDLE.
- Latency: done is high exactly ITER+2 cycles after the accepting edge (34 for defaults). busy is high for ITER+1 cycles and falls in the done cycle.
- Result select:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Sign rules:
  - Quotient is negative iff the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Boundary cases (RISC-V spec):
  - Divide by zero: quotient = all ones; remainder = in1.
  - Signed overflow (-2^31 / -1): quotient = 0x80000000; remainder = 0.
  - These cases still take the full latency unless the optional feature is enabled.
- start in the same cycle as done is ignored; the unit accepts from the following IDLE cycle.

Optional Feature:
- Macro: MD_EARLY_OUT_EN.
- Defined:
  - In PREP, a divisor of zero, or a multiply with either operand zero, jumps directly to FIX with the spec result preloaded.
  - done then arrives 2 cycles after the accepting edge. Other operations are unchanged.
- Undefined: every operation takes ITER+2 cycles; no zero-detect logic is built.

Decomposition:
- Shared package md_pkg:
  - md_op encodings (MD_MUL..MD_REMU).
  - FSM state encoding (IDLE, PREP, CALC, FIX).
  - XLEN default.
- One natural sub-module: md_iter_core, the per-cycle shift-add / shift-subtract datapath step. The FSM, sign handling and result select stay in md_unit.

Test Plan:
- Reset mid-op: start MUL 7*6, assert rst_n=0 at cycle 10 -> busy=0, done never pulses, md_out=0.
- MUL in1=0xFFFFFFFE, in2=14 -> done at +34, md_out=0xFFFFFFE4. Same operands with MULHU -> 0x0000000D; with MULH -> 0xFFFFFFFF.
- DIV in1=-7 (0xFFFFFFF9), in2=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU -> 2.
- DIV by zero, in1=0x12345678: DIV -> 0xFFFFFFFF; REM -> 0x12345678. Without MD_EARLY_OUT_EN done is at +34; with it, at +2.
- Overflow DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Handshake: start held high continuously -> start is accepted only in IDLE (back-to-back ops 35 cycles apart), exactly one done per op, md_out stable between done pulses.

Source files
------------

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared encodings for the RV32M multiply/divide unit.
//  Revision    : 1.0
// ============================================================================
package md_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_FIX  = 2'd3
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input md_op_e op);
        return (op == MD_REM) || (op == MD_REMU);
    endfunction

    function automatic logic op_in1_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op_in2_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : md_iter_core
//  Description : One radix-2 step: shift-add multiply or restoring divide.
//  Revision    : 1.0
// ============================================================================
module md_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_nxt
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rem_hi;
    logic [XLEN:0] w_diff;

    always_comb begin
        w_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        // Partial remainder after shifting in the next dividend bit
        w_rem_hi = acc[2*XLEN-1:XLEN-1];
        w_diff   = w_rem_hi - {1'b0, opnd};
        if (is_div) begin
            if (!w_diff[XLEN]) begin
                acc_nxt = {w_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {w_rem_hi[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {w_sum, acc[XLEN-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Iterative RV32M multiply/divide unit with start/busy/done.
//                Optional zero-operand early completion: MD_EARLY_OUT_EN.
//  Revision    : 1.0
// ============================================================================
module md_unit
    import md_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [2:0]      md_op,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] md_out
);

    localparam int                 c_CNT_W    = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ITER - 1);

    md_state_e           r_state, w_state_nxt;
    md_op_e              r_op;
    logic [XLEN-1:0]     r_in1, r_in2, r_opnd, r_md_out;
    logic [2*XLEN-1:0]   r_acc, w_acc_nxt, w_prod;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_neg;

    logic                w_is_div, w_in1_neg, w_in2_neg, w_in2_zero, w_neg;
    logic [XLEN-1:0]     w_mag1, w_mag2, w_quo, w_rem, w_result;

    md_iter_core #(.XLEN(XLEN)) u_core (
        .is_div  (w_is_div),
        .acc     (r_acc),
        .opnd    (r_opnd),
        .acc_nxt (w_acc_nxt)
    );

    always_comb begin
        w_is_div   = op_is_div(r_op);
        w_in1_neg  = op_in1_signed(r_op) & r_in1[XLEN-1];
        w_in2_neg  = op_in2_signed(r_op) & r_in2[XLEN-1];
        w_mag1     = w_in1_neg ? -r_in1 : r_in1;
        w_mag2     = w_in2_neg ? -r_in2 : r_in2;
        w_in2_zero = (r_in2 == '0);
        // Divide by zero must yield all ones, so its quotient is never negated
        if (op_is_rem(r_op))             w_neg = w_in1_neg;
        else if (w_is_div && w_in2_zero) w_neg = 1'b0;
        else                             w_neg = w_in1_neg ^ w_in2_neg;

        w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
        w_quo  = r_neg ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
        w_rem  = r_neg ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
        case (r_op)
            MD_MUL:                       w_result = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              w_result = w_quo;
            default:                      w_result = w_rem;
        endcase
    end

`ifdef MD_EARLY_OUT_EN
    logic            w_early;
    logic [XLEN-1:0] w_early_res;

    always_comb begin
        w_early     = w_is_div ? w_in2_zero : ((r_in1 == '0) || w_in2_zero);
        w_early_res = '0;
        if (w_is_div) w_early_res = op_is_rem(r_op) ? r_in1 : '1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_PREP;
            S_PREP: begin
`ifdef MD_EARLY_OUT_EN
                if (w_early) w_state_nxt = S_FIX;
                else         w_state_nxt = S_CALC;
`else
                w_state_nxt = S_CALC;
`endif
            end
            S_CALC: if (r_cnt == c_CNT_LAST) w_state_nxt = S_FIX;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in1    <= '0;
            r_in2    <= '0;
            r_op     <= MD_MUL;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_md_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_in1 <= in1;
                        r_in2 <= in2;
                        r_op  <= md_op_e'(md_op);
                    end
                end
                S_PREP: begin
                    r_cnt <= '0;
                    r_neg <= w_neg;
                    // Multiply shifts the multiplier out of the low half; divide shifts the dividend
                    if (w_is_div) begin
                        r_acc  <= {{XLEN{1'b0}}, w_mag1};
                        r_opnd <= w_mag2;
                    end else begin
                        r_acc  <= {{XLEN{1'b0}}, w_mag2};
                        r_opnd <= w_mag1;
                    end
`ifdef MD_EARLY_OUT_EN
                    if (w_early) r_md_out <= w_early_res;
`endif
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_CNT_LAST) r_md_out <= w_result;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state == S_PREP) || (r_state == S_CALC);
    assign done   = (r_state == S_FIX);
    assign md_out = r_md_out;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_unit
//  Description : Directed self-checking bench for md_unit.
//  Revision    : 1.0
// ============================================================================
module tb_md_unit;
    import md_pkg::*;

`ifdef MD_EARLY_OUT_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 34;
`endif
    localparam int FULL_LAT = 34;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic [2:0]  md_op = '0;
    logic        busy, done;
    logic [31:0] md_out;

    int n_tests = 0;
    int n_fail  = 0;

    md_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .in1    (in1),
        .in2    (in2),
        .md_op  (md_op),
        .busy   (busy),
        .done   (done),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    // Drives one operation; lat counts edges from the accepting edge to the edge that samples done
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        int edges;
        @(negedge clk);
        start = 1'b1; in1 = a; in2 = b; md_op = op;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        while (done !== 1'b1 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        res = md_out;
        lat = (done === 1'b1) ? edges + 1 : -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if (md_out !== 32'h0) begin n_fail++; $display("FAIL reset_md_out: got %h expected 0", md_out); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [2:0]  ov [6] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd1, 3'd3};
        logic [31:0] av [6] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] bv [6] = '{32'd14, 32'd14, 32'd14, 32'd14, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] ev [6] = '{32'hFFFFFFE4, 32'h0000000D, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFE};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(ov[i], av[i], bv[i], res, lat);
            n_tests++; if (res !== ev[i]) begin n_fail++; $display("FAIL mul[%0d]_result: got %h expected %h", i, res, ev[i]); end
            n_tests++; if (lat != FULL_LAT) begin n_fail++; $display("FAIL mul[%0d]_latency: got %0d expected %0d", i, lat, FULL_LAT); end
            if (i == 0) begin
                @(negedge clk);
                n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b expected 0", done); end
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ov [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] av [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'hFFFFFF9C, 32'hFFFFFF9C};
        logic [31:0] bv [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] ev [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'd14, 32'hFFFFFFFE};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(ov[i], av[i], bv[i], res, lat);
            n_tests++; if (res !== ev[i]) begin n_fail++; $display("FAIL div[%0d]_result: got %h expected %h", i, res, ev[i]); end
            n_tests++; if (lat != FULL_LAT) begin n_fail++; $display("FAIL div[%0d]_latency: got %0d expected %0d", i, lat, FULL_LAT); end
        end
    endtask

    task automatic test_zero_operand();
        logic [2:0]  ov [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd0};
        logic [31:0] av [6] = '{32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h80000001, 32'h0};
        logic [31:0] bv [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd5};
        logic [31:0] ev [6] = '{32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h0};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(ov[i], av[i], bv[i], res, lat);
            n_tests++; if (res !== ev[i]) begin n_fail++; $display("FAIL zero[%0d]_result: got %h expected %h", i, res, ev[i]); end
            n_tests++; if (lat != ZERO_LAT) begin n_fail++; $display("FAIL zero[%0d]_latency: got %0d expected %0d", i, lat, ZERO_LAT); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] res;
        int lat;
        do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, res, lat);
        n_tests++; if (res !== 32'h80000000) begin n_fail++; $display("FAIL ovf_div: got %h expected 80000000", res); end
        n_tests++; if (lat != FULL_LAT) begin n_fail++; $display("FAIL ovf_div_latency: got %0d expected %0d", lat, FULL_LAT); end
        do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, res, lat);
        n_tests++; if (res !== 32'h0) begin n_fail++; $display("FAIL ovf_rem: got %h expected 00000000", res); end
    endtask

    task automatic test_reset_mid_op();
        logic seen_done;
        logic seen_busy;
        @(negedge clk);
        start = 1'b1; in1 = 32'd7; in2 = 32'd6; md_op = 3'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
        n_tests++; if (md_out !== 32'h0) begin n_fail++; $display("FAIL midrst_md_out: got %h expected 0", md_out); end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen_done |= (done !== 1'b0);
            seen_busy |= (busy !== 1'b0);
        end
        n_tests++; if (seen_done) begin n_fail++; $display("FAIL midrst_no_done: got done pulse expected none"); end
        n_tests++; if (seen_busy) begin n_fail++; $display("FAIL midrst_no_busy: got busy expected idle"); end
    endtask

    task automatic test_back_to_back();
        int  rises, dones, last_rise, gap_bad, unstable;
        logic prev_busy;
        logic have_out;
        @(negedge clk);
        start = 1'b1; in1 = 32'd100; in2 = 32'd7; md_op = 3'd5;
        rises = 0; dones = 0; last_rise = 0; gap_bad = 0; unstable = 0;
        prev_busy = 1'b0; have_out = 1'b0;
        for (int k = 1; k <= 105; k++) begin
            @(negedge clk);
            if (busy === 1'b1 && !prev_busy) begin
                if (rises > 0 && (k - last_rise) != 35) gap_bad++;
                rises++;
                last_rise = k;
            end
            prev_busy = (busy === 1'b1);
            if (done === 1'b1) begin
                dones++;
                have_out = 1'b1;
            end
            if (have_out && md_out !== 32'd14) unstable++;
        end
        start = 1'b0;
        repeat (40) @(negedge clk);
        n_tests++; if (rises != 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 3", rises); end
        n_tests++; if (gap_bad != 0) begin n_fail++; $display("FAIL b2b_spacing: got %0d bad gaps expected 0", gap_bad); end
        n_tests++; if (dones != 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 3", dones); end
        n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL b2b_md_out_stable: got %0d changes expected 0", unstable); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_reset_mid_op();
        test_div();
        test_zero_operand();
        test_overflow();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
